// File: rtl/vscale_hasti_arbiter.sv
// ============================================================================
// vscale_hasti_arbiter
// ----------------------------------------------------------------------------
// Purpose:
//   Shares one HASTI (AHB-lite) slave port between two masters. A typical
//   setup is the on-chip SRAM as the slave, with the core's imem port as m0
//   and its dmem port as m1.
//
//   The address phase of the winning master goes straight through to the
//   slave. The arbiter records which master owns the data phase that
//   follows, and it stalls any master that is requesting but was not
//   granted by pulling that master's hready low.
//
//   A master can finish a data phase in the same cycle that its next
//   address phase is refused. In that case the slave's read data and
//   response are captured into a per-master hold register. The held values
//   are shown to that master until it is granted again.
//
// Ports:
//   hclk, hresetn            clock, asynchronous active-low reset
//   mN_haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans
//                            master N address phase (inputs)
//   mN_hwdata                master N write data (data phase, input)
//   mN_hrdata/hready/hresp   read data, ready and response back to master N
//   s_haddr ... s_htrans     muxed address phase to the slave
//   s_hwdata                 write data of the current data-phase owner
//   s_hrdata/hready/hresp    slave read data, ready and response
// ============================================================================
module vscale_hasti_arbiter (
    input  logic        hclk,
    input  logic        hresetn,

    input  logic [31:0] m0_haddr,
    input  logic        m0_hwrite,
    input  logic [2:0]  m0_hsize,
    input  logic [2:0]  m0_hburst,
    input  logic        m0_hmastlock,
    input  logic [3:0]  m0_hprot,
    input  logic [1:0]  m0_htrans,
    input  logic [31:0] m0_hwdata,
    output logic [31:0] m0_hrdata,
    output logic        m0_hready,
    output logic        m0_hresp,

    input  logic [31:0] m1_haddr,
    input  logic        m1_hwrite,
    input  logic [2:0]  m1_hsize,
    input  logic [2:0]  m1_hburst,
    input  logic        m1_hmastlock,
    input  logic [3:0]  m1_hprot,
    input  logic [1:0]  m1_htrans,
    input  logic [31:0] m1_hwdata,
    output logic [31:0] m1_hrdata,
    output logic        m1_hready,
    output logic        m1_hresp,

    output logic [31:0] s_haddr,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [2:0]  s_hburst,
    output logic        s_hmastlock,
    output logic [3:0]  s_hprot,
    output logic [1:0]  s_htrans,
    output logic [31:0] s_hwdata,
    input  logic [31:0] s_hrdata,
    input  logic        s_hready,
    input  logic        s_hresp
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic       HRESP_OKAY  = 1'b0;

    // Registered arbitration and data-phase state
    logic        last_grant;
    logic        lock_valid;
    logic        lock_owner;
    logic        dp_valid;
    logic        dp_owner;

    // Per-master hold registers
    logic [1:0]  hold_valid;
    logic [1:0]  hold_resp;
    logic [31:0] hold_data [2];

    // Combinational arbitration results
    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  denied;
    logic [1:0]  owns_dp;
    logic [1:0]  hready_int;
    logic        grant_any;
    logic        winner;
    logic        lock_still_held;
    logic        winner_lock;

    // NONSEQ and SEQ both have htrans[1] set. IDLE and BUSY never ask for
    // the bus.
    assign req = {m1_htrans[1], m0_htrans[1]};

    // The lock holder keeps the bus only while it is still requesting and
    // still asserting hmastlock.
    assign lock_still_held = lock_owner ? (req[1] && m1_hmastlock)
                                        : (req[0] && m0_hmastlock);

    // Winner selection. Nothing is granted while the slave is stalling,
    // because an address phase is only accepted on an hready-high edge.
    // The order is: lock holder first, then a lone requester, and
    // round-robin when both masters request.
    always_comb begin
        grant_any = 1'b0;
        winner    = 1'b0;
        if (s_hready) begin
            if (lock_valid && lock_still_held) begin
                grant_any = 1'b1;
                winner    = lock_owner;
            end else if (req[0] && req[1]) begin
                grant_any = 1'b1;
                winner    = ~last_grant;
            end else if (req[0]) begin
                grant_any = 1'b1;
                winner    = 1'b0;
            end else if (req[1]) begin
                grant_any = 1'b1;
                winner    = 1'b1;
            end
        end
    end

    assign grant       = {grant_any && winner, grant_any && !winner};
    assign denied      = req & ~grant;
    assign owns_dp     = {dp_valid && dp_owner, dp_valid && !dp_owner};
    assign winner_lock = winner ? m1_hmastlock : m0_hmastlock;

    // Arbitration history and lock tracking. These only move when the slave
    // accepts an address phase. When a cycle grants nothing, the previous
    // owner has gone idle or dropped its lock, so the lock is released.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            last_grant <= 1'b1;
            lock_valid <= 1'b0;
            lock_owner <= 1'b0;
        end else if (s_hready) begin
            if (grant_any) begin
                last_grant <= winner;
                lock_owner <= winner;
                lock_valid <= winner_lock;
            end else begin
                lock_valid <= 1'b0;
            end
        end
    end

    // Data-phase ownership follows the address phase that was just
    // accepted. It is frozen while the slave inserts wait states.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_owner <= 1'b0;
        end else if (s_hready) begin
            dp_valid <= grant_any;
            dp_owner <= winner;
        end
    end

    // Hold capture and release. A master whose data phase completes while
    // its next request is refused would otherwise miss the slave's data,
    // because its hready is low on that edge. The values are parked here
    // until the master wins the bus again. Capture and release cannot
    // happen in the same cycle: capture needs the master to be refused,
    // and release needs it to be granted.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hold_valid   <= 2'b00;
            hold_resp    <= 2'b00;
            hold_data[0] <= 32'h0;
            hold_data[1] <= 32'h0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s_hready && owns_dp[i] && denied[i]) begin
                    hold_valid[i] <= 1'b1;
                    hold_resp[i]  <= s_hresp;
                    hold_data[i]  <= s_hrdata;
                end else if (grant[i]) begin
                    hold_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Ready back to each master. A refused request stalls the master. A
    // master that owns the data phase sees the slave's hready. Anyone else
    // is free to proceed.
    always_comb begin
        hready_int = 2'b11;
        for (int i = 0; i < 2; i++) begin
            if (denied[i]) begin
                hready_int[i] = 1'b0;
            end else if (owns_dp[i]) begin
                hready_int[i] = s_hready;
            end
        end
    end

    assign m0_hready = hready_int[0];
    assign m1_hready = hready_int[1];

    // Held values take precedence over live slave data. A response is only
    // passed through to the master that actually owns the data phase.
    assign m0_hrdata = hold_valid[0] ? hold_data[0] : s_hrdata;
    assign m1_hrdata = hold_valid[1] ? hold_data[1] : s_hrdata;
    assign m0_hresp  = hold_valid[0] ? hold_resp[0]
                                     : (owns_dp[0] ? s_hresp : HRESP_OKAY);
    assign m1_hresp  = hold_valid[1] ? hold_resp[1]
                                     : (owns_dp[1] ? s_hresp : HRESP_OKAY);

    // Address-phase mux. When nothing is granted, winner is 0, so the slave
    // sees m0's fields together with an IDLE transfer.
    assign s_haddr     = winner ? m1_haddr     : m0_haddr;
    assign s_hwrite    = winner ? m1_hwrite    : m0_hwrite;
    assign s_hsize     = winner ? m1_hsize     : m0_hsize;
    assign s_hburst    = winner ? m1_hburst    : m0_hburst;
    assign s_hmastlock = winner ? m1_hmastlock : m0_hmastlock;
    assign s_hprot     = winner ? m1_hprot     : m0_hprot;
    assign s_htrans    = grant_any ? (winner ? m1_htrans : m0_htrans)
                                   : HTRANS_IDLE;

    // Write data belongs to whoever owns the current data phase
    assign s_hwdata = dp_owner ? m1_hwdata : m0_hwdata;

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// ============================================================================
// tb_vscale_hasti_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for the two-master HASTI arbiter. Directed scenarios
// cover reset, a single read, round-robin ties, hold capture, slave wait
// states, locked sequences and reset with a pending hold. A randomized run
// then compares every output against a behavioural model of the
// arbitration rules. The model uses -1 to mean "nobody" for the winner,
// the lock holder and the data-phase owner.
// ============================================================================
module tb_vscale_hasti_arbiter;

    logic        hclk;
    logic        hresetn;

    logic [31:0] haddr     [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic        hmastlock [2];
    logic [3:0]  hprot     [2];
    logic [1:0]  htrans    [2];
    logic [31:0] hwdata    [2];

    logic [31:0] m0_hrdata, m1_hrdata;
    logic        m0_hready, m1_hready;
    logic        m0_hresp,  m1_hresp;

    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [2:0]  s_hburst;
    logic        s_hmastlock;
    logic [3:0]  s_hprot;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;

    int n_compared;
    int n_mismatched;

    // Reference model state
    int          mdl_last;
    int          mdl_lock_owner;
    int          mdl_dp_owner;
    bit          mdl_hold_valid [2];
    logic [31:0] mdl_hold_data  [2];
    logic        mdl_hold_resp  [2];

    // Model predictions for the current cycle
    int          exp_winner;
    logic        exp_hready [2];
    logic [31:0] exp_hrdata [2];
    logic        exp_hresp  [2];
    logic [1:0]  exp_htrans;
    int          exp_sel;

    vscale_hasti_arbiter dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .m0_haddr    (haddr[0]),
        .m0_hwrite   (hwrite[0]),
        .m0_hsize    (hsize[0]),
        .m0_hburst   (hburst[0]),
        .m0_hmastlock(hmastlock[0]),
        .m0_hprot    (hprot[0]),
        .m0_htrans   (htrans[0]),
        .m0_hwdata   (hwdata[0]),
        .m0_hrdata   (m0_hrdata),
        .m0_hready   (m0_hready),
        .m0_hresp    (m0_hresp),
        .m1_haddr    (haddr[1]),
        .m1_hwrite   (hwrite[1]),
        .m1_hsize    (hsize[1]),
        .m1_hburst   (hburst[1]),
        .m1_hmastlock(hmastlock[1]),
        .m1_hprot    (hprot[1]),
        .m1_htrans   (htrans[1]),
        .m1_hwdata   (hwdata[1]),
        .m1_hrdata   (m1_hrdata),
        .m1_hready   (m1_hready),
        .m1_hresp    (m1_hresp),
        .s_haddr     (s_haddr),
        .s_hwrite    (s_hwrite),
        .s_hsize     (s_hsize),
        .s_hburst    (s_hburst),
        .s_hmastlock (s_hmastlock),
        .s_hprot     (s_hprot),
        .s_htrans    (s_htrans),
        .s_hwdata    (s_hwdata),
        .s_hrdata    (s_hrdata),
        .s_hready    (s_hready),
        .s_hresp     (s_hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // A transfer is a request when it is NONSEQ or SEQ
    function automatic bit is_req(int i);
        return (htrans[i] == 2'b10) || (htrans[i] == 2'b11);
    endfunction

    function automatic void model_reset();
        mdl_last       = 1;
        mdl_lock_owner = -1;
        mdl_dp_owner   = -1;
        for (int i = 0; i < 2; i++) begin
            mdl_hold_valid[i] = 1'b0;
            mdl_hold_data[i]  = 32'h0;
            mdl_hold_resp[i]  = 1'b0;
        end
    endfunction

    // Predicts the combinational outputs from the model state and the
    // current inputs
    function automatic void model_eval();
        exp_winner = -1;
        if (s_hready) begin
            if (mdl_lock_owner >= 0 && is_req(mdl_lock_owner) && hmastlock[mdl_lock_owner])
                exp_winner = mdl_lock_owner;
            else if (is_req(0) && is_req(1))
                exp_winner = 1 - mdl_last;
            else if (is_req(0))
                exp_winner = 0;
            else if (is_req(1))
                exp_winner = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (is_req(i) && exp_winner != i)
                exp_hready[i] = 1'b0;
            else if (mdl_dp_owner == i)
                exp_hready[i] = s_hready;
            else
                exp_hready[i] = 1'b1;
            exp_hrdata[i] = mdl_hold_valid[i] ? mdl_hold_data[i] : s_hrdata;
            exp_hresp[i]  = mdl_hold_valid[i] ? mdl_hold_resp[i]
                                              : ((mdl_dp_owner == i) ? s_hresp : 1'b0);
        end
        exp_sel    = (exp_winner < 0) ? 0 : exp_winner;
        exp_htrans = (exp_winner < 0) ? 2'b00 : htrans[exp_winner];
    endfunction

    // Advances the model by one clock edge. Inputs must still hold the
    // values they had during the cycle being closed.
    function automatic void model_clock();
        model_eval();
        if (s_hready) begin
            for (int i = 0; i < 2; i++) begin
                if (mdl_dp_owner == i && is_req(i) && exp_winner != i) begin
                    mdl_hold_valid[i] = 1'b1;
                    mdl_hold_data[i]  = s_hrdata;
                    mdl_hold_resp[i]  = s_hresp;
                end else if (exp_winner == i) begin
                    mdl_hold_valid[i] = 1'b0;
                end
            end
            if (exp_winner >= 0) begin
                mdl_last       = exp_winner;
                mdl_lock_owner = hmastlock[exp_winner] ? exp_winner : -1;
            end else begin
                mdl_lock_owner = -1;
            end
            mdl_dp_owner = exp_winner;
        end
    endfunction

    task automatic set_master(input int i, input logic [1:0] t, input logic [31:0] a,
                              input logic w, input logic lk);
        htrans[i]    = t;
        haddr[i]     = a;
        hwrite[i]    = w;
        hmastlock[i] = lk;
        hsize[i]     = 3'b010;
        hburst[i]    = 3'b000;
        hprot[i]     = 4'b0011;
    endtask

    task automatic all_idle();
        for (int i = 0; i < 2; i++) begin
            set_master(i, 2'b00, 32'h0, 1'b0, 1'b0);
            hwdata[i] = 32'h0;
        end
        s_hready = 1'b1;
        s_hrdata = 32'h0;
        s_hresp  = 1'b0;
    endtask

    // Closes the current cycle in both DUT and model, then leaves time
    // 1 ns past the edge for driving the next inputs
    task automatic step();
        @(posedge hclk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        all_idle();
        hresetn = 1'b0;
        model_reset();
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        all_idle();
        hresetn = 1'b0;
        model_reset();
        #2;
        n_compared++;
        if (m0_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_m0_hready got %b want 1", m0_hready); end
        n_compared++;
        if (m1_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_m1_hready got %b want 1", m1_hready); end
        n_compared++;
        if (m0_hresp !== 1'b0 || m1_hresp !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_hresp got %b/%b want 0/0", m0_hresp, m1_hresp); end
        n_compared++;
        if (s_htrans !== 2'b00) begin n_mismatched++; $display("[TB] FAIL reset_s_htrans got %b want 00", s_htrans); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        set_master(0, 2'b10, 32'h100, 1'b0, 1'b0);
        @(negedge hclk);
        n_compared++;
        if (s_htrans !== 2'b10 || s_haddr !== 32'h100) begin n_mismatched++; $display("[TB] FAIL single_addr got %b/%h want 10/00000100", s_htrans, s_haddr); end
        n_compared++;
        if (m0_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_hready0 got %b want 1", m0_hready); end
        step();
        set_master(0, 2'b00, 32'h0, 1'b0, 1'b0);
        s_hrdata = 32'hDEADBEEF;
        @(negedge hclk);
        n_compared++;
        if (m0_hrdata !== 32'hDEADBEEF || m0_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL single_rdata got %h/%b want deadbeef/1", m0_hrdata, m0_hready); end
        step();
    endtask

    task automatic test_tie_round_robin();
        do_reset();
        set_master(0, 2'b10, 32'h10, 1'b0, 1'b0);
        set_master(1, 2'b10, 32'h20, 1'b0, 1'b0);
        @(negedge hclk);
        n_compared++;
        if (s_haddr !== 32'h10 || m0_hready !== 1'b1 || m1_hready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_first got addr %h hready %b%b want 00000010 10", s_haddr, m0_hready, m1_hready); end
        step();
        set_master(0, 2'b00, 32'h0, 1'b0, 1'b0);
        @(negedge hclk);
        n_compared++;
        if (s_haddr !== 32'h20 || m1_hready !== 1'b1 || m0_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL tie_second got addr %h hready %b%b want 00000020 11", s_haddr, m0_hready, m1_hready); end
        step();
        set_master(0, 2'b10, 32'h14, 1'b0, 1'b0);
        set_master(1, 2'b10, 32'h24, 1'b0, 1'b0);
        @(negedge hclk);
        n_compared++;
        if (s_haddr !== 32'h14 || m1_hready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL tie_third got addr %h m1_hready %b want 00000014 0", s_haddr, m1_hready); end
        step();
        all_idle();
        step();
    endtask

    task automatic test_hold_capture();
        do_reset();
        set_master(1, 2'b10, 32'h200, 1'b0, 1'b0);
        step();
        set_master(0, 2'b10, 32'h300, 1'b0, 1'b0);
        set_master(1, 2'b10, 32'h204, 1'b0, 1'b0);
        s_hrdata = 32'h12345678;
        @(negedge hclk);
        n_compared++;
        if (s_haddr !== 32'h300 || m1_hready !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_deny got addr %h m1_hready %b want 00000300 0", s_haddr, m1_hready); end
        step();
        set_master(0, 2'b00, 32'h0, 1'b0, 1'b0);
        s_hrdata = 32'hAAAA5555;
        @(negedge hclk);
        n_compared++;
        if (m1_hready !== 1'b1 || m1_hrdata !== 32'h12345678) begin n_mismatched++; $display("[TB] FAIL hold_release got %b/%h want 1/12345678", m1_hready, m1_hrdata); end
        n_compared++;
        if (m0_hrdata !== 32'hAAAA5555) begin n_mismatched++; $display("[TB] FAIL hold_m0_live got %h want aaaa5555", m0_hrdata); end
        step();
        set_master(1, 2'b00, 32'h0, 1'b0, 1'b0);
        s_hrdata = 32'h0BADF00D;
        @(negedge hclk);
        n_compared++;
        if (m1_hrdata !== 32'h0BADF00D) begin n_mismatched++; $display("[TB] FAIL hold_cleared got %h want 0badf00d", m1_hrdata); end
        step();
    endtask

    task automatic test_wait_states();
        do_reset();
        set_master(0, 2'b10, 32'h400, 1'b1, 1'b0);
        step();
        set_master(0, 2'b00, 32'h0, 1'b0, 1'b0);
        set_master(1, 2'b10, 32'h500, 1'b0, 1'b0);
        s_hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            hwdata[0] = 32'h11111111 * (k + 1);
            @(negedge hclk);
            n_compared++;
            if (m0_hready !== 1'b0 || m1_hready !== 1'b0 || s_htrans !== 2'b00) begin n_mismatched++; $display("[TB] FAIL wait_stall k=%0d got %b%b htrans %b want 00 00", k, m0_hready, m1_hready, s_htrans); end
            n_compared++;
            if (s_hwdata !== hwdata[0]) begin n_mismatched++; $display("[TB] FAIL wait_hwdata k=%0d got %h want %h", k, s_hwdata, hwdata[0]); end
            step();
        end
        s_hready = 1'b1;
        @(negedge hclk);
        n_compared++;
        if (m1_hready !== 1'b1 || m0_hready !== 1'b1 || s_haddr !== 32'h500 || s_htrans !== 2'b10) begin n_mismatched++; $display("[TB] FAIL wait_resume got %b%b addr %h want 11 00000500", m0_hready, m1_hready, s_haddr); end
        step();
        all_idle();
        step();
    endtask

    task automatic test_lock();
        do_reset();
        set_master(1, 2'b10, 32'h600, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_master(0, 2'b10, 32'h700 + 32'(4 * k), 1'b0, 1'b1);
            @(negedge hclk);
            n_compared++;
            if (s_haddr !== 32'h700 + 32'(4 * k) || m1_hready !== 1'b0 || m0_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lock_hold k=%0d got addr %h hready %b%b", k, s_haddr, m0_hready, m1_hready); end
            step();
        end
        set_master(0, 2'b00, 32'h0, 1'b0, 1'b0);
        @(negedge hclk);
        n_compared++;
        if (s_haddr !== 32'h600 || m1_hready !== 1'b1) begin n_mismatched++; $display("[TB] FAIL lock_release got addr %h m1_hready %b want 00000600 1", s_haddr, m1_hready); end
        step();
        all_idle();
        step();
    endtask

    task automatic test_reset_with_hold();
        do_reset();
        set_master(1, 2'b10, 32'h200, 1'b0, 1'b0);
        step();
        set_master(0, 2'b10, 32'h300, 1'b0, 1'b1);
        set_master(1, 2'b10, 32'h204, 1'b0, 1'b0);
        s_hrdata = 32'hCAFEF00D;
        step();
        set_master(0, 2'b10, 32'h304, 1'b0, 1'b1);
        s_hrdata = 32'h00000011;
        @(negedge hclk);
        n_compared++;
        if (m1_hready !== 1'b0 || m1_hrdata !== 32'hCAFEF00D) begin n_mismatched++; $display("[TB] FAIL rsthold_pending got %b/%h want 0/cafef00d", m1_hready, m1_hrdata); end
        all_idle();
        s_hrdata = 32'h55AA55AA;
        hresetn  = 1'b0;
        model_reset();
        #1;
        n_compared++;
        if (m1_hready !== 1'b1 || s_htrans !== 2'b00 || m1_hrdata !== 32'h55AA55AA) begin n_mismatched++; $display("[TB] FAIL rsthold_cleared got %b htrans %b rdata %h want 1 00 55aa55aa", m1_hready, s_htrans, m1_hrdata); end
        @(negedge hclk);
        hresetn = 1'b1;
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                htrans[i]    = 2'($urandom_range(0, 3));
                haddr[i]     = $urandom;
                hwrite[i]    = 1'($urandom);
                hsize[i]     = 3'($urandom);
                hburst[i]    = 3'($urandom);
                hprot[i]     = 4'($urandom);
                hmastlock[i] = ($urandom_range(0, 9) < 3);
                hwdata[i]    = $urandom;
            end
            s_hready = ($urandom_range(0, 9) < 7);
            s_hrdata = $urandom;
            s_hresp  = ($urandom_range(0, 9) == 0);
            @(negedge hclk);
            model_eval();
            n_compared++;
            if (m0_hready !== exp_hready[0] || m1_hready !== exp_hready[1]) begin n_mismatched++; $display("[TB] FAIL rand_hready c=%0d got %b%b want %b%b", c, m0_hready, m1_hready, exp_hready[0], exp_hready[1]); end
            n_compared++;
            if (m0_hrdata !== exp_hrdata[0] || m1_hrdata !== exp_hrdata[1]) begin n_mismatched++; $display("[TB] FAIL rand_hrdata c=%0d got %h/%h want %h/%h", c, m0_hrdata, m1_hrdata, exp_hrdata[0], exp_hrdata[1]); end
            n_compared++;
            if (m0_hresp !== exp_hresp[0] || m1_hresp !== exp_hresp[1]) begin n_mismatched++; $display("[TB] FAIL rand_hresp c=%0d got %b%b want %b%b", c, m0_hresp, m1_hresp, exp_hresp[0], exp_hresp[1]); end
            n_compared++;
            if (s_htrans !== exp_htrans) begin n_mismatched++; $display("[TB] FAIL rand_htrans c=%0d got %b want %b", c, s_htrans, exp_htrans); end
            n_compared++;
            if (s_haddr !== haddr[exp_sel] || s_hwrite !== hwrite[exp_sel] || s_hsize !== hsize[exp_sel]
                || s_hburst !== hburst[exp_sel] || s_hprot !== hprot[exp_sel] || s_hmastlock !== hmastlock[exp_sel]) begin
                n_mismatched++;
                $display("[TB] FAIL rand_addr_phase c=%0d got addr %h want %h (master %0d)", c, s_haddr, haddr[exp_sel], exp_sel);
            end
            if (mdl_dp_owner >= 0) begin
                n_compared++;
                if (s_hwdata !== hwdata[mdl_dp_owner]) begin n_mismatched++; $display("[TB] FAIL rand_hwdata c=%0d got %h want %h", c, s_hwdata, hwdata[mdl_dp_owner]); end
            end
            step();
        end
        all_idle();
        step();
    endtask

    // Time-limit guard so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached with %0d compared", n_compared);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        hresetn      = 1'b0;
        all_idle();
        model_reset();
        #12;
        test_reset();
        test_single_read();
        test_tie_round_robin();
        test_hold_capture();
        test_wait_states();
        test_lock();
        test_reset_with_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_arbiter.md
Name: vscale_hasti_arbiter

Overview:
- Two-master to one-slave HASTI (AHB-lite) arbiter that shares a single slave port between two masters.
- Typical slave: the on-chip SRAM. Typical masters: core imem port (m0) and dmem port (m1).
- Forwards the winning master's address phase, tracks data-phase ownership and stalls the losing master via its hready.
- Holds read data and response for a master whose data phase completes while its next address phase is being denied.

Parameters:
- none (fixed 2 masters, 32-bit address and data)

Ports:
- hclk  input  1  clock
- hresetn  input  1  reset; asynchronous, active-low
- m0_haddr, m1_haddr  input  32  master address
- m0_hwrite, m1_hwrite  input  1  master write
- m0_hsize, m1_hsize  input  3  master size
- m0_hburst, m1_hburst  input  3  master burst (forwarded only)
- m0_hmastlock, m1_hmastlock  input  1  master lock request
- m0_hprot, m1_hprot  input  4  master prot (forwarded)
- m0_htrans, m1_htrans  input  2  master trans
- m0_hwdata, m1_hwdata  input  32  master write data (data phase)
- m0_hrdata, m1_hrdata  output  32  read data to master
- m0_hready, m1_hready  output  1  ready to master
- m0_hresp, m1_hresp  output  1  response to master
- s_haddr, s_hwrite, s_hsize, s_hburst, s_hmastlock, s_hprot, s_htrans  output  32/1/3/3/1/4/2  muxed address phase to slave
- s_hwdata  output  32  muxed write data to slave
- s_hrdata  input  32  slave read data
- s_hready  input  1  slave ready
- s_hresp  input  1  slave response

Behaviour:
- Request: req[i] = mi_htrans[1] (NONSEQ or SEQ). IDLE and BUSY are not requests.
- Arbitration is evaluated only when s_hready=1; no master is granted when s_hready=0.
- Priority order:
  1. Lock holder: lock_valid set, lock_owner still requesting with hmastlock=1 → lock_owner wins.
  2. Single requester wins.
  3. Both requesting → winner = ~last_grant (round-robin).
- On a grant: last_grant<=winner. lock_valid<=winner's hmastlock; lock_owner<=winner.
- Lock is released when the owner issues IDLE or deasserts hmastlock.
- Slave address-phase outputs are combinational from the winner. With no winner: s_htrans=IDLE (2'b00), other s_ address outputs are don't-care but driven from m0.
- Data phase tracking: registers dp_valid and dp_owner, updated only when s_hready=1: dp_valid<=grant_any, dp_owner<=winner.
- s_hwdata = dp_owner's hwdata.
- mi_hready:
  - 0 if req[i] and not granted this cycle (this includes s_hready=0).
  - else s_hready if dp_valid and dp_owner==i.
  - else 1.
- Hold capture: if s_hready=1, dp_valid, dp_owner==i and master i is denied this cycle:
  - hold_data[i]<=s_hrdata, hold_resp[i]<=s_hresp, hold_valid[i]<=1.
- While hold_valid[i]=1:
  - mi_hrdata=hold_data[i], mi_hresp=hold_resp[i].
  - hold_valid[i] clears in the cycle master i is granted; in that cycle mi_hready=1.
- Otherwise mi_hrdata=s_hrdata. mi_hresp=s_hresp when i owns the data phase, else OKAY.
- A granted master never has both a held and a live slave data phase: hold is only set when ownership ends.
- Latency: uncontested transfer adds zero cycles; the loser waits ≥1 cycle.
- Reset (hresetn low, any time):
  - dp_valid=0, hold_valid=0, lock_valid=0, last_grant=1 (m0 wins first tie).
  - Outputs: mi_hready=1, mi_hresp=OKAY, s_htrans=IDLE while both masters IDLE.
  - Reset mid-transfer discards all held data.
- Simultaneous events: a denied owner whose data phase completes captures into hold in the same edge that the winner's address is accepted.

Test Plan:
- Reset, then m0 reads 0x100 alone (slave returns 0xDEADBEEF, s_hready=1) → s_htrans=NONSEQ addr 0x100 in cycle 0; m0_hready=1; m0_hrdata=0xDEADBEEF in cycle 1.
- Both masters issue NONSEQ in the same cycle → m0 granted first (last_grant=1); m1_hready=0 for 1 cycle; next cycle m1 granted; the following tie grants m0.
- m1 read 0x200 in data phase, m1 issues next NONSEQ while m0 is granted; slave returns 0x12345678 → hold_valid[1]=1, m1_hready stays 0; when m1 is later granted, m1_hready=1 and m1_hrdata=0x12345678.
- s_hready=0 for 3 cycles during m0 write data phase with m1 requesting → both hready=0; s_hwdata tracks m0_hwdata; no grant change until s_hready=1.
- m0 holds hmastlock=1 over 4 NONSEQ transfers with m1 requesting → m0 granted all 4; m1 granted on the cycle m0 drops lock/IDLE.
- hresetn asserted while hold_valid[1]=1 → hold cleared asynchronously; m1_hready=1, s_htrans=IDLE immediately.
